muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative RV32M multiply/divide unit with its own sequencing FSM, used alongside the single-cycle ALU in the EX stage of the pipeline. Accepts one M-extension operation (opcode 0110011, funct7 0000001) at a time via a valid/ready handshake. Runs a 32-step shift-add multiply or restoring divide, then returns a one-cycle result pulse. The pipeline holds EX while a request is outstanding.

## Interface
- WIDTH, 32, operand/result width; step count equals WIDTH
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  kill in-flight op (branch mispredict/redirect); synchronous
- req_valid  in  1  EX holds an M-extension instruction
- req_ready  out  1  unit can accept; high only in IDLE
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_v  in  WIDTH  operand a (dividend/multiplicand)
- rs2_v  in  WIDTH  operand b (divisor/multiplier)
- resp_valid  out  1  one-cycle pulse; resp_data valid
- resp_data  out  WIDTH  result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE → accept when req_valid & req_ready. Latch funct3. Latch magnitudes of operands per signedness: MUL/MULH/DIV/REM both operands signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned. Latch neg_result flag. Load count = WIDTH.
  - Multiply ops → MUL.
  - Divide ops with b == 0 → DONE directly. Quotient = all ones; remainder = a unmodified.
  - DIV/REM with a == 0x80000000, b == 0xFFFFFFFF → DONE directly. Quotient = 0x80000000; remainder = 0.
  - Other divide ops → DIV.
- MUL: 2·WIDTH-bit accumulator; one multiplier bit per cycle, shift-add. count decrements; at count == 1 → DONE.
- DIV: restoring; one quotient bit per cycle, trial subtract on a WIDTH+1-bit remainder. count decrements; at count == 1 → DONE.
- DONE: resp_valid = 1 for exactly one cycle, then → IDLE.
  - Sign correction is applied in DONE via two's-complement negate, modulo 2^(2·WIDTH) for products.
  - MUL: low word. MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient is negative iff operand signs differ. Remainder sign follows the dividend.
- flush: any state → IDLE next cycle. No resp_valid is produced for the killed op. flush in the cycle of acceptance cancels that acceptance.
- rst has priority over flush.
- Consumer is always ready: the pipeline advances EX on resp_valid, so no back-pressure on resp.

## Timing
- Reset values:
  - state = IDLE, count = 0, accumulators = 0
  - req_ready = 1, busy = 0, resp_valid = 0, resp_data = 0
- Latency, with accept at edge k:
  - resp_valid is high in cycle k+33 for MUL/DIV paths.
  - resp_valid is high in cycle k+1 for the divide-by-zero and overflow fast paths.
- req_ready is 0 in MUL, DIV and DONE. The earliest back-to-back accept is the cycle after DONE: 34-cycle issue interval.
- resp_data is registered and holds its value after DONE until the next DONE.
- Pipeline stall = req_valid & ~resp_valid (formed outside this block).
- rst or flush mid-operation: IDLE on the next edge; the partial result is discarded.

## Structure
- Shared package muldiv_pkg:
  - muldiv_op_e enum keyed on funct3 values
  - muldiv_state_e {IDLE, MUL, DIV, DONE}
  - M_FUNCT7 = 7'b0000001
  - OPCODE_OP = 7'b0110011
- Top module: FSM, count, handshake, fast paths, sign correction.
- One sub-module, muldiv_step: combinational single iteration. Inputs are mode, accumulator and operand; outputs are the next accumulator (shift-add or trial-subtract).

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → resp_data 0xFFFFFFEB, resp_valid exactly one cycle at k+33, busy high k+1..k+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at k+1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- flush at k+10 of a MUL → no resp_valid, req_ready = 1 at k+11. A new DIV 9/3 accepted at k+11 → 3 at k+44.
- rst at k+5 mid-DIV → all outputs at reset values next cycle. Back-to-back MUL ops with req_valid held → second accept exactly one cycle after the first resp_valid.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] M_FUNCT7  = 7'b0000001;
    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Decode helper for the issue logic that steers instructions to this unit.
    function automatic logic is_m_ext(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == M_FUNCT7);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply or restoring-divide trial subtract.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_e         mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             fits;

    // Multiply: acc = {partial_hi, multiplier_remaining}. Divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        fits      = rem_shift >= {1'b0, operand};
        rem_diff  = WIDTH'(rem_shift - {1'b0, operand});
        if (mode == STEP_DIV) begin
            if (fits) acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
            else      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: operand magnitudes in, WIDTH steps, sign fix-up on the way out.
// state | meaning
// IDLE  | ready for a request        MUL | shift-add multiply steps
// DIV   | restoring divide steps     DONE | one-cycle result pulse
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_v,
    input  logic [WIDTH-1:0] rs2_v,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] acc_q, step_next;
    logic [WIDTH-1:0]   operand_q;
    muldiv_op_e         op_q;
    logic               neg_q;

    logic               accept, is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
    logic               div_zero, div_ovf, fast_path;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_data;
    step_mode_e         step_mode;

    function automatic logic [WIDTH-1:0] finalize(input muldiv_op_e op, input logic neg,
                                                  input logic [2*WIDTH-1:0] acc);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   quo, rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            OP_MUL:                      return prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             return quo;
            default:                     return rem;
        endcase
    endfunction

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign accept     = req_valid & req_ready & ~flush;

    // Signedness: multiplies key off funct3[1:0], divides off funct3[0].
    always_comb begin
        is_div    = funct3[2];
        a_signed  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed  = is_div ? ~funct3[0] : ~funct3[1];
        a_neg     = a_signed & rs1_v[WIDTH-1];
        b_neg     = b_signed & rs2_v[WIDTH-1];
        a_mag     = a_neg ? -rs1_v : rs1_v;
        b_mag     = b_neg ? -rs2_v : rs2_v;
        neg_d     = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div && (rs2_v == '0);
        div_ovf   = is_div && !funct3[0] && (rs1_v == MIN_INT) && (rs2_v == '1);
        fast_path = div_zero | div_ovf;
        if (div_zero) fast_data = funct3[1] ? rs1_v : '1;
        else          fast_data = funct3[1] ? '0 : MIN_INT;
    end

    assign step_mode = (state_q == DIV) ? STEP_DIV : STEP_MUL;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (step_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_div)        state_d = MUL;
                    else if (fast_path) state_d = DONE;
                    else                state_d = DIV;
                end
            end
            MUL, DIV: if (count_q == CNT_W'(1)) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            resp_data <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= muldiv_op_e'(funct3);
                        neg_q     <= neg_d;
                        count_q   <= CNT_W'(WIDTH);
                        acc_q     <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                        operand_q <= is_div ? b_mag : a_mag;
                        if (fast_path) resp_data <= fast_data;
                    end
                end
                MUL, DIV: begin
                    acc_q   <= step_next;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) resp_data <= finalize(op_q, neg_q, step_next);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results and their cycle of arrival are scoreboarded.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_rv = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .rs1_v      (rs1_v),
        .rs2_v      (rs2_v),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: every response must match the head of the scoreboard, in data and in arrival cycle.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_cycle", cyc, e.cyc);
            end
            if (prev_rv) check("resp_pulse_width", 32'd2, 32'd1);
        end
        prev_rv = (resp_valid === 1'b1);
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit track, input bit hold);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", req_ready, 1);
        funct3    = f;
        rs1_v     = a;
        rs2_v     = b;
        req_valid = 1'b1;
        if (track) sb.push_back('{exp, cyc + 1 + lat});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; funct3 = 3'b000; rs1_v = '0; rs2_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 * -3 with cycle-by-cycle busy/valid checks
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 1, 0);
        @(negedge clk);
        check("mul_busy_k1", busy, 1);
        check("mul_ready_k1", req_ready, 0);
        check("mul_valid_k1", resp_valid, 0);
        repeat (31) @(negedge clk);
        check("mul_valid_k32", resp_valid, 0);
        check("mul_busy_k32", busy, 1);
        @(negedge clk);
        check("mul_valid_k33", resp_valid, 1);
        check("mul_busy_k33", busy, 1);
        @(negedge clk);
        check("mul_valid_k34", resp_valid, 0);
        check("mul_busy_k34", busy, 0);
        check("mul_ready_k34", req_ready, 1);
        drain();

        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 1, 0); drain();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 1, 0); drain();
        issue(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32, 1, 0); drain();
        issue(3'b001, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32, 1, 0); drain();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 1, 0); drain();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 1, 0); drain();
        issue(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 1, 0); drain();
        issue(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         32, 1, 0); drain();
        issue(3'b101, 32'd100,       32'd7,         32'd14,        32, 1, 0); drain();
        issue(3'b111, 32'd100,       32'd7,         32'd2,         32, 1, 0); drain();
        issue(3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 32, 1, 0); drain();

        // Fast paths: divide by zero and signed overflow answer one cycle after accept
        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1, 0);
        @(negedge clk);
        check("divz_valid_k1", resp_valid, 1);
        drain();
        issue(3'b110, 32'd5,         32'd0,         32'd5,         0, 1, 0); drain();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0); drain();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 1, 0); drain();

        // Flush in cycle k+10 of a MUL, then DIV 9/3 accepted at k+11
        issue(3'b000, 32'd123, 32'd456, 32'h0, 32, 0, 0);
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("pre_flush_ready", req_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", req_ready, 1);
        check("flush_busy", busy, 0);
        issue(3'b100, 32'd9, 32'd3, 32'd3, 32, 1, 0);
        drain();

        // Reset in cycle k+5 of a DIV
        issue(3'b100, 32'd1000, 32'd7, 32'h0, 32, 0, 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_data", resp_data, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_quiet", sb.size(), 0);

        // Back-to-back MULs with req_valid held: second accept one cycle after first resp
        issue(3'b000, 32'd11, 32'd13, 32'd143, 32, 1, 1);
        sb.push_back('{32'h0071_C6F4, sb[sb.size()-1].cyc + 34});
        rs1_v = 32'h0001_2345;
        rs2_v = 32'd100;
        @(negedge clk);
        repeat (33) @(negedge clk);
        check("b2b_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
